router_pkt_fifo: RTL and testbench
==================================

# router_pkt_fifo

Parametrised, packet-aware synchronous FIFO for the router 1x3 output channels. It generalises the fixed 8x16 channel FIFO to configurable width, depth and thresholds. It tracks packet boundaries on both the write and read sides using the header length field, and reports occupancy, complete-packet count, almost-full/almost-empty flags, and per-word header/last markers to the downstream read logic. There is one instance per output port, between the router FSM/register write path and the output read interface.

## Interface
- WIDTH, 8, data word width; must be at least 3. Header bits [WIDTH-1:2] hold the payload length and bits [1:0] the address.
- DEPTH, 16, number of entries; must be a power of two.
- ADD_WIDTH, 4, log2(DEPTH).
- AFULL_TH, 14, almost_full asserts when count >= AFULL_TH.
- AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH.

Ports:
- clock  in  1  single clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- soft_reset  in  1  synchronous flush, active-high.
- write_enb  in  1  write request.
- lfd_state  in  1  marks the current data_in word as a packet header.
- data_in  in  WIDTH  write data.
- read_enb  in  1  read request.
- data_out  out  WIDTH  registered read data.
- rd_lfd  out  1  data_out is a header word.
- pkt_done  out  1  data_out is the last word (the parity word) of a packet.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.
- count  out  ADD_WIDTH+1  current occupancy.
- pkt_count  out  ADD_WIDTH+1  number of complete packets currently resident.
- overflow  out  1  sticky; set when a write is attempted while full.

## Operation
- Storage is DEPTH x (WIDTH+1). The extra bit stores lfd_state alongside each word.
- Pointers are ADD_WIDTH bits wide and wrap modulo DEPTH.
- Write is accepted when write_enb and !full. A write attempted while full is dropped and sets overflow.
- Read is accepted when read_enb and !empty. A read attempted while empty is ignored and all outputs hold.
- When full, a simultaneous read and write still drops the write. When empty, a simultaneous read and write still ignores the read.
- A simultaneous accepted read and write leaves count unchanged.
- Write-side packet tracker (wr_rem counter, WIDTH-1 bits):
  - An accepted write with lfd_state=1 loads wr_rem = data_in[WIDTH-1:2] + 1, covering payload plus parity.
  - Every other accepted write with wr_rem != 0 decrements wr_rem.
  - The decrement from 1 to 0 increments pkt_count.
  - A header written while wr_rem != 0 abandons the old packet: no pkt_count increment, and wr_rem reloads.
- Read-side tracker (rd_rem counter) applies the same rules to the stored lfd bit and word:
  - A read that decrements rd_rem from 1 to 0 sets pkt_done and decrements pkt_count.
  - A non-header word read while rd_rem == 0 (orphan) is delivered with rd_lfd=0 and pkt_done=0.
- If pkt_count increments and decrements on the same edge, pkt_count is unchanged.
- soft_reset, when high at a rising edge:
  - Clears pointers, count, pkt_count, wr_rem, rd_rem, data_out, rd_lfd, pkt_done and overflow.
  - Overrides any read or write requested in the same cycle.
  - Memory contents are not cleared.
- resetn low asynchronously forces the same state as soft_reset.

## Timing
- Reset values: data_out=0, rd_lfd=0, pkt_done=0, count=0, pkt_count=0, empty=1, full=0, almost_full=0, almost_empty=1, overflow=0.
- Write-to-flag latency: count and flags reflect an accepted write immediately after the same rising edge.
- Write-to-read: a word written at edge N can be read at edge N+1 at the earliest.
- Read latency: data_out, rd_lfd and pkt_done update on the edge that accepts the read; they are valid one cycle after read_enb is sampled.
- rd_lfd and pkt_done are single-cycle: they clear on the next edge unless another accepted read sets them again.
- data_out holds its last value when no read is accepted.
- Flags are combinational decodes of registered count, so they carry no extra cycle of lag.
- Back-to-back reads sustain one word per clock.
- A packet longer than DEPTH needs concurrent reading. The tracker counters are WIDTH-1 bits, independent of DEPTH.

## Test plan
- Reset: assert resetn=0 mid-operation with count=5 -> all outputs take reset values asynchronously, before the next edge.
- Single packet: write header 0x15 (len 5, lfd=1), 5 payload words, parity (7 writes) -> pkt_count=1 after the 7th edge. Reading 7 words returns rd_lfd=1 on word 1 and pkt_done=1 on word 7; pkt_count=0 and empty=1 afterwards.
- Full/overflow: write 17 words with DEPTH=16 -> full=1 and almost_full=1 (from count 14), 17th word dropped, overflow=1. Read 16 words -> data matches the first 16 writes in order.
- Wrap plus simultaneous access: hold count=8 with read_enb=write_enb=1 for 40 cycles -> count stays 8, data stays in order, pointers wrap at least twice.
- Soft reset precedence: with count=10 and pkt_count=1, pulse soft_reset together with write_enb and read_enb -> next cycle count=0, pkt_count=0, empty=1, data_out=0, overflow=0.
- Abandoned header: write header len 3, 1 payload word, then a new header len 0 plus parity -> pkt_count=1, not 2. Reading yields the orphan words without pkt_done, then the valid packet with rd_lfd and pkt_done.

Source files
------------

// File: rtl/router_pkt_fifo.sv
// Packet-aware synchronous FIFO for one router output channel. Each stored word
// carries its header (lfd) bit so the read side can re-derive packet boundaries.
module router_pkt_fifo #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 16,
   parameter int ADD_WIDTH = 4,
   parameter int AFULL_TH  = 14,
   parameter int AEMPTY_TH = 2
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 soft_reset,
   input  logic                 write_enb,
   input  logic                 lfd_state,
   input  logic [WIDTH-1:0]     data_in,
   input  logic                 read_enb,
   output logic [WIDTH-1:0]     data_out,
   output logic                 rd_lfd,
   output logic                 pkt_done,
   output logic                 empty,
   output logic                 full,
   output logic                 almost_full,
   output logic                 almost_empty,
   output logic [ADD_WIDTH:0]   count,
   output logic [ADD_WIDTH:0]   pkt_count,
   output logic                 overflow
);

   localparam logic [ADD_WIDTH-1:0] PTR_ONE  = ADD_WIDTH'(1);
   localparam logic [ADD_WIDTH:0]   CNT_ONE  = (ADD_WIDTH+1)'(1);
   localparam logic [ADD_WIDTH:0]   CNT_FULL = (ADD_WIDTH+1)'(DEPTH);
   localparam logic [ADD_WIDTH:0]   AF_TH    = (ADD_WIDTH+1)'(AFULL_TH);
   localparam logic [ADD_WIDTH:0]   AE_TH    = (ADD_WIDTH+1)'(AEMPTY_TH);
   localparam logic [WIDTH-2:0]     REM_ONE  = (WIDTH-1)'(1);

   logic [WIDTH:0]         mem [DEPTH];
   logic [WIDTH:0]         rd_word;

   logic [ADD_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADD_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ADD_WIDTH:0]     count_q, count_d;
   logic [ADD_WIDTH:0]     pkt_cnt_q, pkt_cnt_d;
   logic [WIDTH-2:0]       wr_rem_q, wr_rem_d;
   logic [WIDTH-2:0]       rd_rem_q, rd_rem_d;
   logic [WIDTH-1:0]       dout_q, dout_d;
   logic                   rd_lfd_q, rd_lfd_d;
   logic                   pkt_done_q, pkt_done_d;
   logic                   ovf_q, ovf_d;

   logic                   wr_acc, rd_acc, pkt_inc, pkt_dec;

   assign empty        = (count_q == '0);
   assign full         = (count_q == CNT_FULL);
   assign almost_full  = (count_q >= AF_TH);
   assign almost_empty = (count_q <= AE_TH);
   assign count        = count_q;
   assign pkt_count    = pkt_cnt_q;
   assign data_out     = dout_q;
   assign rd_lfd       = rd_lfd_q;
   assign pkt_done     = pkt_done_q;
   assign overflow     = ovf_q;

   assign wr_acc  = write_enb && !full && !soft_reset;
   assign rd_acc  = read_enb && !empty && !soft_reset;
   assign rd_word = mem[rd_ptr_q];

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      pkt_cnt_d  = pkt_cnt_q;
      wr_rem_d   = wr_rem_q;
      rd_rem_d   = rd_rem_q;
      dout_d     = dout_q;
      rd_lfd_d   = 1'b0;
      pkt_done_d = 1'b0;
      ovf_d      = ovf_q;
      pkt_inc    = 1'b0;
      pkt_dec    = 1'b0;

      // A header reloads the tracker even mid-packet, abandoning the old one.
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (lfd_state) begin
            wr_rem_d = {1'b0, data_in[WIDTH-1:2]} + REM_ONE;
         end else if (wr_rem_q != '0) begin
            wr_rem_d = wr_rem_q - REM_ONE;
            pkt_inc  = (wr_rem_q == REM_ONE);
         end
      end

      if (write_enb && full) ovf_d = 1'b1;

      // Read side replays the same rules on the stored lfd bit and word.
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
         dout_d   = rd_word[WIDTH-1:0];
         if (rd_word[WIDTH]) begin
            rd_rem_d = {1'b0, rd_word[WIDTH-1:2]} + REM_ONE;
            rd_lfd_d = 1'b1;
         end else if (rd_rem_q != '0) begin
            rd_rem_d   = rd_rem_q - REM_ONE;
            pkt_done_d = (rd_rem_q == REM_ONE);
            pkt_dec    = (rd_rem_q == REM_ONE) && (pkt_cnt_q != '0);
         end
      end

      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      if (pkt_inc && !pkt_dec)      pkt_cnt_d = pkt_cnt_q + CNT_ONE;
      else if (!pkt_inc && pkt_dec) pkt_cnt_d = pkt_cnt_q - CNT_ONE;

      if (soft_reset) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         pkt_cnt_d  = '0;
         wr_rem_d   = '0;
         rd_rem_d   = '0;
         dout_d     = '0;
         rd_lfd_d   = 1'b0;
         pkt_done_d = 1'b0;
         ovf_d      = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         pkt_cnt_q  <= '0;
         wr_rem_q   <= '0;
         rd_rem_q   <= '0;
         dout_q     <= '0;
         rd_lfd_q   <= 1'b0;
         pkt_done_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         pkt_cnt_q  <= pkt_cnt_d;
         wr_rem_q   <= wr_rem_d;
         rd_rem_q   <= rd_rem_d;
         dout_q     <= dout_d;
         rd_lfd_q   <= rd_lfd_d;
         pkt_done_q <= pkt_done_d;
         ovf_q      <= ovf_d;
      end
   end

   // Storage is not reset; pointers alone define what is valid.
   always_ff @(posedge clock) begin
      if (wr_acc) mem[wr_ptr_q] <= {lfd_state, data_in};
   end

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Directed bench for router_pkt_fifo: queue scoreboard of {data, lfd, done}
// pushed on accepted writes and popped on accepted reads.
module tb_router_pkt_fifo;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       soft_reset = 1'b0;
   logic       write_enb = 1'b0;
   logic       lfd_state = 1'b0;
   logic [7:0] data_in = '0;
   logic       read_enb = 1'b0;
   logic [7:0] data_out;
   logic       rd_lfd, pkt_done, empty, full, almost_full, almost_empty, overflow;
   logic [4:0] count, pkt_count;

   router_pkt_fifo dut (
      .clock(clock), .resetn(resetn), .soft_reset(soft_reset),
      .write_enb(write_enb), .lfd_state(lfd_state), .data_in(data_in),
      .read_enb(read_enb), .data_out(data_out), .rd_lfd(rd_lfd),
      .pkt_done(pkt_done), .empty(empty), .full(full),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .count(count), .pkt_count(pkt_count), .overflow(overflow)
   );

   always #5 clock = ~clock;

   int vec = 0;
   int errs = 0;
   logic [9:0] sbq[$];
   int   m_cnt = 0, m_pkt = 0, m_rem = 0;
   bit   m_ovf = 1'b0;
   logic [7:0] m_dout = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_state();
      check("count", 32'(count), 32'(m_cnt));
      check("pkt_count", 32'(pkt_count), 32'(m_pkt));
      check("empty", 32'(empty), 32'(m_cnt == 0));
      check("full", 32'(full), 32'(m_cnt == 16));
      check("almost_full", 32'(almost_full), 32'(m_cnt >= 14));
      check("almost_empty", 32'(almost_empty), 32'(m_cnt <= 2));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("data_out", 32'(data_out), 32'(m_dout));
   endtask

   task automatic model_clear();
      sbq.delete();
      m_cnt = 0; m_pkt = 0; m_rem = 0; m_ovf = 1'b0; m_dout = '0;
   endtask

   // One clock: drive, clock, then check everything #1 after the edge.
   task automatic cyc(input bit we, input bit lfd, input logic [7:0] din, input bit re);
      bit wacc, racc, done;
      logic [9:0] e;
      write_enb = we; lfd_state = lfd; data_in = din; read_enb = re;
      wacc = we && (m_cnt < 16);
      racc = re && (m_cnt > 0);
      @(posedge clock); #1;
      if (racc) begin
         e = sbq.pop_front();
         m_dout = e[9:2];
         check("rd_lfd", 32'(rd_lfd), 32'(e[1]));
         check("pkt_done", 32'(pkt_done), 32'(e[0]));
         if (e[0]) m_pkt--;
      end else begin
         check("rd_lfd_idle", 32'(rd_lfd), 32'd0);
         check("pkt_done_idle", 32'(pkt_done), 32'd0);
      end
      if (wacc) begin
         done = 1'b0;
         if (lfd) m_rem = int'(din[7:2]) + 1;
         else if (m_rem != 0) begin
            done = (m_rem == 1);
            m_rem--;
         end
         if (done) m_pkt++;
         sbq.push_back({din, lfd, done});
      end
      if (we && m_cnt == 16) m_ovf = 1'b1;
      m_cnt = m_cnt + int'(wacc) - int'(racc);
      check_state();
      write_enb = 1'b0; lfd_state = 1'b0; data_in = '0; read_enb = 1'b0;
   endtask

   task automatic soft_flush(input bit we, input bit re);
      soft_reset = 1'b1; write_enb = we; read_enb = re; data_in = 8'hEE;
      @(posedge clock); #1;
      soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0; data_in = '0;
      model_clear();
      check_state();
      check("sr_rd_lfd", 32'(rd_lfd), 32'd0);
      check("sr_pkt_done", 32'(pkt_done), 32'd0);
   endtask

   initial begin
      // Reset values
      #12;
      check_state();
      check("rst_rd_lfd", 32'(rd_lfd), 32'd0);
      check("rst_pkt_done", 32'(pkt_done), 32'd0);
      @(negedge clock); resetn = 1'b1;

      // Asynchronous reset mid-operation with five words held
      for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'h30 + i), 0);
      cyc(0, 0, 0, 1);
      cyc(1, 0, 8'h3A, 0);
      resetn = 1'b0;
      #2;
      model_clear();
      check_state();
      check("arst_rd_lfd", 32'(rd_lfd), 32'd0);
      @(negedge clock); resetn = 1'b1;

      // Single packet: header len 5, 5 payload, parity
      cyc(1, 1, 8'h15, 0);
      for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'hA0 + i), 0);
      cyc(1, 0, 8'h5C, 0);
      for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0);

      // Fill past full, then simultaneous access while full, then drain
      for (int i = 0; i < 17; i++) cyc(1, 0, 8'(8'h40 + i), 0);
      cyc(1, 0, 8'hF0, 1);
      for (int i = 0; i < 15; i++) cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      cyc(1, 0, 8'h77, 1);
      cyc(0, 0, 0, 1);

      // Wrap: hold eight words with concurrent read/write for 40 cycles
      for (int i = 0; i < 8; i++) cyc(1, 0, 8'(8'h80 + i), 0);
      for (int i = 0; i < 40; i++) cyc(1, 0, 8'(8'h88 + i), 1);
      soft_flush(0, 0);

      // Soft reset precedence with count 10 and one complete packet
      cyc(1, 1, 8'h0D, 0);
      for (int i = 0; i < 4; i++) cyc(1, 0, 8'(8'hB0 + i), 0);
      for (int i = 0; i < 6; i++) cyc(1, 0, 8'(8'hC0 + i), 0);
      cyc(0, 0, 0, 1);
      soft_flush(1, 1);

      // Abandoned header: len 3 header, one payload, then len 0 header + parity
      cyc(1, 1, 8'h0C, 0);
      cyc(1, 0, 8'hA1, 0);
      cyc(1, 1, 8'h00, 0);
      cyc(1, 0, 8'h55, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
